// File: rtl/lvl_sensor_frontend_if.sv
`default_nettype none
// ============================================================================
// Module  : lvl_sensor_frontend_if
// Brief   : Sensor pins and pump-controller level outputs of the front end.
// Rev     : 1.0  initial release
// ============================================================================
interface lvl_sensor_frontend_if;
   logic       echo;
   logic       trig;
   logic [7:0] water_lvl;
   logic       lvl_valid;
   logic       sensor_fault;
   logic [7:0] dist_cm;

   modport master (
      input  echo,
      output trig,
      output water_lvl,
      output lvl_valid,
      output sensor_fault,
      output dist_cm
   );

   modport slave (
      output echo,
      input  trig,
      input  water_lvl,
      input  lvl_valid,
      input  sensor_fault,
      input  dist_cm
   );
endinterface
`default_nettype wire

// File: rtl/lvl_sensor_frontend.sv
`default_nettype none
// ============================================================================
// Module  : lvl_sensor_frontend
// Brief   : Ultrasonic trigger/echo timing, cm-to-percent conversion and
//           4-sample moving average feeding the pump controller.
// Rev     : 1.0  initial release
// ============================================================================
module lvl_sensor_frontend #(
   parameter int TRIG_CYCLES      = 1000,
   parameter int PERIOD_CYCLES    = 6000000,
   parameter int TICKS_PER_CM     = 5831,
   parameter int ECHO_WAIT_CYCLES = 3000000,
   parameter int EMPTY_CM         = 120,
   parameter int MAX_CM           = 255
) (
   input  logic                  clock,
   input  logic                  rst_n,
   lvl_sensor_frontend_if.master bus
);

   localparam int c_wait_max = (TRIG_CYCLES > ECHO_WAIT_CYCLES) ? TRIG_CYCLES : ECHO_WAIT_CYCLES;
   localparam int c_cnt_w    = $clog2(c_wait_max + 1);
   localparam int c_per_w    = $clog2(PERIOD_CYCLES + 1);
   localparam int c_tick_w   = $clog2(TICKS_PER_CM + 1);

   localparam logic [c_cnt_w-1:0]  c_trig_last = c_cnt_w'(TRIG_CYCLES - 1);
   localparam logic [c_cnt_w-1:0]  c_wait_last = c_cnt_w'(ECHO_WAIT_CYCLES - 1);
   localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
   localparam logic [c_per_w-1:0]  c_per_last  = c_per_w'(PERIOD_CYCLES - 1);
   localparam logic [c_per_w-1:0]  c_per_one   = c_per_w'(1);
   localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICKS_PER_CM - 1);
   localparam logic [c_tick_w-1:0] c_tick_one  = c_tick_w'(1);
   localparam logic [7:0]          c_cm_pre    = 8'(MAX_CM - 1);
   localparam logic [7:0]          c_empty     = 8'(EMPTY_CM);
   localparam logic [7:0]          c_pct_max   = 8'd100;

   localparam logic [2:0] c_st_idle = 3'd0;
   localparam logic [2:0] c_st_trig = 3'd1;
   localparam logic [2:0] c_st_wait = 3'd2;
   localparam logic [2:0] c_st_meas = 3'd3;
   localparam logic [2:0] c_st_proc = 3'd4;
   localparam logic [2:0] c_st_filt = 3'd5;
   localparam logic [2:0] c_st_fail = 3'd6;

   logic                r_echo_meta;
   logic                r_echo_s;
   logic                r_echo_prev;
   logic                w_echo_rise;
   logic                w_echo_fall;

   logic [c_per_w-1:0]  r_period;
   logic                w_period_exp;

   logic [2:0]          r_state;
   logic [2:0]          w_state_nxt;
   logic                w_trig_entry;

   logic [c_cnt_w-1:0]  r_cnt;
   logic [c_tick_w-1:0] r_tick;
   logic [7:0]          r_cm;
   logic                w_tick_wrap;
   logic                w_cm_hit;

   logic [7:0]          w_raw_full;
   logic [7:0]          w_raw;
   logic [7:0]          r_raw;
   logic [3:0][7:0]     r_hist;
   logic                r_primed;
   logic [9:0]          w_sum;
   logic [7:0]          w_avg;

   logic [1:0]          r_fail_cnt;
   logic                r_fault;
   logic [7:0]          r_water;
   logic                r_valid;
   logic [7:0]          r_dist;
   logic                r_trig;

   // Echo is asynchronous: two flops before any use, a third for edge detection.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_echo_meta <= 1'b0;
         r_echo_s    <= 1'b0;
         r_echo_prev <= 1'b0;
      end else begin
         r_echo_meta <= bus.echo;
         r_echo_s    <= r_echo_meta;
         r_echo_prev <= r_echo_s;
      end
   end

   assign w_echo_rise = r_echo_s & ~r_echo_prev;
   assign w_echo_fall = ~r_echo_s & r_echo_prev;

   assign w_period_exp = (r_period == c_per_last);
   assign w_trig_entry = (w_state_nxt == c_st_trig) && (r_state != c_st_trig);

   // Free-running between triggers; holding at expiry lets IDLE fire late
   // when a measurement overran the period.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_period <= c_per_last;
      end else if (w_trig_entry) begin
         r_period <= '0;
      end else if (!w_period_exp) begin
         r_period <= r_period + c_per_one;
      end
   end

   assign w_tick_wrap = (r_tick == c_tick_last);
   assign w_cm_hit    = w_tick_wrap && (r_cm == c_cm_pre);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: if (w_period_exp) w_state_nxt = c_st_trig;
         c_st_trig: if (r_cnt == c_trig_last) w_state_nxt = c_st_wait;
         c_st_wait: begin
            if (w_echo_rise) begin
               w_state_nxt = c_st_meas;
            end else if (r_cnt == c_wait_last) begin
               w_state_nxt = c_st_fail;
            end
         end
         c_st_meas: begin
            if (w_cm_hit) begin
               w_state_nxt = c_st_fail;
            end else if (w_echo_fall) begin
               w_state_nxt = c_st_proc;
            end
         end
         c_st_proc: w_state_nxt = c_st_filt;
         c_st_filt: w_state_nxt = c_st_idle;
         c_st_fail: w_state_nxt = c_st_idle;
         default:   w_state_nxt = c_st_idle;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_st_idle;
         r_trig  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_trig  <= (w_state_nxt == c_st_trig);
      end
   end

   // Shared dwell counter for the trigger pulse and the echo-wait timeout.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (((r_state == c_st_trig) || (r_state == c_st_wait)) &&
                   (w_state_nxt == r_state)) begin
         r_cnt <= r_cnt + c_cnt_one;
      end else begin
         r_cnt <= '0;
      end
   end

   // The falling-edge cycle is counted too, so the cm count covers every
   // cycle echo_s was high.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_tick <= '0;
         r_cm   <= 8'd0;
      end else if ((r_state == c_st_wait) && w_echo_rise) begin
         r_tick <= '0;
         r_cm   <= 8'd0;
      end else if (r_state == c_st_meas) begin
         if (w_tick_wrap) begin
            r_tick <= '0;
            r_cm   <= r_cm + 8'd1;
         end else begin
            r_tick <= r_tick + c_tick_one;
         end
      end
   end

   always_comb begin
      w_raw_full = 8'd0;
      if (r_cm < c_empty) begin
         w_raw_full = c_empty - r_cm;
      end
      w_raw = (w_raw_full > c_pct_max) ? c_pct_max : w_raw_full;
   end

   // Sum over the history as it will look after this sample is taken.
   always_comb begin
      if (!r_primed) begin
         w_sum = {r_raw, 2'b00};
      end else begin
         w_sum = {2'b00, r_raw} + {2'b00, r_hist[0]} +
                 {2'b00, r_hist[1]} + {2'b00, r_hist[2]};
      end
      w_avg = w_sum[9:2];
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_raw      <= 8'd0;
         r_dist     <= 8'd0;
         r_hist     <= '0;
         r_primed   <= 1'b0;
         r_water    <= 8'd0;
         r_valid    <= 1'b0;
         r_fail_cnt <= 2'd0;
         r_fault    <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            c_st_proc: begin
               r_raw      <= w_raw;
               r_dist     <= r_cm;
               r_fail_cnt <= 2'd0;
               r_fault    <= 1'b0;
            end
            c_st_filt: begin
               if (!r_primed) begin
                  r_hist <= {4{r_raw}};
               end else begin
                  r_hist <= {r_hist[2:0], r_raw};
               end
               r_primed <= 1'b1;
               r_water  <= w_avg;
               r_valid  <= 1'b1;
            end
            c_st_fail: begin
               if (r_fail_cnt != 2'd3) begin
                  r_fail_cnt <= r_fail_cnt + 2'd1;
               end
               if (r_fail_cnt >= 2'd2) begin
                  r_fault <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.trig         = r_trig;
   assign bus.water_lvl    = r_water;
   assign bus.lvl_valid    = r_valid;
   assign bus.sensor_fault = r_fault;
   assign bus.dist_cm      = r_dist;

endmodule
`default_nettype wire

// File: tb/tb_lvl_sensor_frontend.sv
`default_nettype none
// ============================================================================
// Module  : tb_lvl_sensor_frontend
// Brief   : Directed scenarios for the level-sensor front end.
// Rev     : 1.0  initial release
// ============================================================================
module tb_lvl_sensor_frontend;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   int   valid_cnt = 0;
   bit   valid_prev = 1'b0;
   bit   consec_err = 1'b0;
   bit   range_err = 1'b0;
   bit   trig_prev = 1'b0;
   int   trig_rise_cyc = -1;
   int   last_period = 0;
   int   trig_run = 0;
   int   last_trig_len = 0;

   lvl_sensor_frontend_if bus ();

   lvl_sensor_frontend #(
      .TRIG_CYCLES      (4),
      .PERIOD_CYCLES    (400),
      .TICKS_PER_CM     (2),
      .ECHO_WAIT_CYCLES (100),
      .EMPTY_CM         (120),
      .MAX_CM           (255)
   ) dut (
      .clock (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.lvl_valid) begin
         valid_cnt <= valid_cnt + 1;
         if (valid_prev) consec_err <= 1'b1;
      end
      if (bus.water_lvl > 8'd100) range_err <= 1'b1;
      valid_prev <= bus.lvl_valid;
      if (bus.trig && !trig_prev) begin
         if (trig_rise_cyc >= 0) last_period <= cyc - trig_rise_cyc;
         trig_rise_cyc <= cyc;
         trig_run <= 1;
      end else if (bus.trig) begin
         trig_run <= trig_run + 1;
      end
      if (!bus.trig && trig_prev) last_trig_len <= trig_run;
      trig_prev <= bus.trig;
   end

   task automatic wait_trig_fall(output bit ok);
      int n;
      n = 0;
      while (!bus.trig && n < 1000) begin @(negedge clk); n++; end
      while (bus.trig && n < 1000) begin @(negedge clk); n++; end
      ok = (n < 1000);
   endtask

   // Echo 10 clocks after trig falls, held for width clocks; lat is the
   // number of negedges from echo release to the first lvl_valid (0 = none).
   task automatic echo_shot(input int width, input bit skip_wait, output bit ok, output int lat);
      ok = 1'b1;
      if (!skip_wait) wait_trig_fall(ok);
      repeat (10) @(negedge clk);
      bus.echo = 1'b1;
      repeat (width) @(negedge clk);
      bus.echo = 1'b0;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (bus.lvl_valid && lat == 0) lat = k;
      end
   endtask

   task automatic test_reset();
      int n;
      rst_n = 1'b0;
      bus.echo = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.trig, bus.water_lvl, bus.lvl_valid, bus.sensor_fault, bus.dist_cm} !== 19'd0) begin
         failures++;
         $display("FAIL reset_state trig=%b lvl=%0d valid=%b fault=%b dist=%0d expected all 0",
                  bus.trig, bus.water_lvl, bus.lvl_valid, bus.sensor_fault, bus.dist_cm);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.trig !== 1'b1) begin
         failures++;
         $display("FAIL first_trig trig=%b expected 1 one cycle after release", bus.trig);
      end
      n = 0;
      for (int k = 0; k < 20; k++) begin
         if (bus.trig) n++;
         else break;
         @(negedge clk);
      end
      checks++;
      if (n !== 4) begin
         failures++;
         $display("FAIL trig_width got=%0d expected=4", n);
      end
   endtask

   task automatic test_first_sample();
      bit ok;
      int lat;
      echo_shot(80, 1'b1, ok, lat);
      checks++;
      if (!ok || lat !== 5) begin
         failures++;
         $display("FAIL first_latency ok=%b lat=%0d expected=5", ok, lat);
      end
      checks++;
      if (bus.dist_cm !== 8'd40) begin
         failures++;
         $display("FAIL first_dist got=%0d expected=40", bus.dist_cm);
      end
      checks++;
      if (bus.water_lvl !== 8'd80) begin
         failures++;
         $display("FAIL first_level got=%0d expected=80", bus.water_lvl);
      end
      checks++;
      if (valid_cnt !== 1) begin
         failures++;
         $display("FAIL first_valid_count got=%0d expected=1", valid_cnt);
      end
   endtask

   task automatic test_steady();
      bit ok;
      int lat;
      logic [7:0] exp_lvl [3] = '{8'd70, 8'd60, 8'd50};
      for (int i = 0; i < 3; i++) begin
         echo_shot(160, 1'b0, ok, lat);
         checks++;
         if (!ok || lat !== 5) begin
            failures++;
            $display("FAIL steady_latency[%0d] ok=%b lat=%0d expected=5", i, ok, lat);
         end
         checks++;
         if (bus.water_lvl !== exp_lvl[i]) begin
            failures++;
            $display("FAIL steady_level[%0d] got=%0d expected=%0d", i, bus.water_lvl, exp_lvl[i]);
         end
      end
      checks++;
      if (last_period !== 400) begin
         failures++;
         $display("FAIL trig_period got=%0d expected=400", last_period);
      end
      checks++;
      if (last_trig_len !== 4) begin
         failures++;
         $display("FAIL trig_len got=%0d expected=4", last_trig_len);
      end
   endtask

   task automatic test_saturation();
      bit ok;
      int lat;
      echo_shot(20, 1'b0, ok, lat);
      checks++;
      if (!ok || bus.water_lvl !== 8'd55 || bus.dist_cm !== 8'd10) begin
         failures++;
         $display("FAIL near_sat ok=%b lvl=%0d dist=%0d expected lvl=55 dist=10", ok, bus.water_lvl, bus.dist_cm);
      end
      echo_shot(300, 1'b0, ok, lat);
      checks++;
      if (!ok || bus.water_lvl !== 8'd45 || bus.dist_cm !== 8'd150) begin
         failures++;
         $display("FAIL beyond_empty ok=%b lvl=%0d dist=%0d expected lvl=45 dist=150", ok, bus.water_lvl, bus.dist_cm);
      end
   endtask

   task automatic test_timeout_fault();
      bit ok;
      int lat;
      int v0;
      v0 = valid_cnt;
      for (int i = 0; i < 3; i++) begin
         wait_trig_fall(ok);
         repeat (100) @(negedge clk);
         checks++;
         if (!ok || bus.sensor_fault !== 1'b0) begin
            failures++;
            $display("FAIL fault_early[%0d] ok=%b fault=%b expected 0", i, ok, bus.sensor_fault);
         end
         @(negedge clk);
         checks++;
         if (bus.sensor_fault !== (i == 2)) begin
            failures++;
            $display("FAIL fault_after_timeout[%0d] got=%b expected=%b", i, bus.sensor_fault, (i == 2));
         end
      end
      checks++;
      if (bus.water_lvl !== 8'd45 || valid_cnt !== v0) begin
         failures++;
         $display("FAIL timeout_hold lvl=%0d valids=%0d expected lvl=45 valids=%0d", bus.water_lvl, valid_cnt, v0);
      end
      echo_shot(80, 1'b0, ok, lat);
      checks++;
      if (!ok || bus.sensor_fault !== 1'b0 || bus.water_lvl !== 8'd55) begin
         failures++;
         $display("FAIL fault_clear ok=%b fault=%b lvl=%0d expected fault=0 lvl=55", ok, bus.sensor_fault, bus.water_lvl);
      end
   endtask

   task automatic test_max_cm();
      bit ok;
      int v0;
      v0 = valid_cnt;
      wait_trig_fall(ok);
      repeat (10) @(negedge clk);
      bus.echo = 1'b1;
      repeat (560) @(negedge clk);
      bus.echo = 1'b0;
      repeat (150) @(negedge clk);
      checks++;
      if (!ok || valid_cnt !== v0) begin
         failures++;
         $display("FAIL max_no_valid ok=%b valids=%0d expected=%0d", ok, valid_cnt, v0);
      end
      checks++;
      if (bus.water_lvl !== 8'd55 || bus.dist_cm !== 8'd40) begin
         failures++;
         $display("FAIL max_hold lvl=%0d dist=%0d expected lvl=55 dist=40", bus.water_lvl, bus.dist_cm);
      end
      checks++;
      if (bus.sensor_fault !== 1'b0) begin
         failures++;
         $display("FAIL max_two_fails fault=%b expected 0", bus.sensor_fault);
      end
      // Overflow abort plus the echo-less retry count as two; one more makes three.
      wait_trig_fall(ok);
      repeat (105) @(negedge clk);
      checks++;
      if (!ok || bus.sensor_fault !== 1'b1) begin
         failures++;
         $display("FAIL max_third_fail ok=%b fault=%b expected 1", ok, bus.sensor_fault);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int lat;
      wait_trig_fall(ok);
      repeat (10) @(negedge clk);
      bus.echo = 1'b1;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (!ok || bus.trig !== 1'b0 || bus.water_lvl !== 8'd0 || bus.lvl_valid !== 1'b0 || bus.sensor_fault !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid ok=%b trig=%b lvl=%0d valid=%b fault=%b expected all 0",
                  ok, bus.trig, bus.water_lvl, bus.lvl_valid, bus.sensor_fault);
      end
      bus.echo = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      echo_shot(60, 1'b0, ok, lat);
      checks++;
      if (!ok || lat !== 5) begin
         failures++;
         $display("FAIL reprime_latency ok=%b lat=%0d expected=5", ok, lat);
      end
      checks++;
      if (bus.water_lvl !== 8'd90 || bus.dist_cm !== 8'd30) begin
         failures++;
         $display("FAIL reprime_level lvl=%0d dist=%0d expected lvl=90 dist=30", bus.water_lvl, bus.dist_cm);
      end
   endtask

   task automatic test_invariants();
      checks++;
      if (consec_err !== 1'b0 || range_err !== 1'b0) begin
         failures++;
         $display("FAIL invariants consecutive_valid=%b level_over_100=%b expected 0 0", consec_err, range_err);
      end
   endtask

   initial begin
      test_reset();
      test_first_sample();
      test_steady();
      test_saturation();
      test_timeout_fault();
      test_max_cm();
      test_reset_mid();
      test_invariants();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
